// File: rtl/if_pkg.sv
// Shared constants and the fetch bundle type for the instruction-fetch stage.
package if_pkg;

    localparam int unsigned IF_PC_W     = 32;
    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
    localparam int unsigned IF_PC_STEP  = 2;

    typedef struct packed {
        logic [IF_PC_W-1:0] pc;
        logic [31:0]        ir;
    } fetch_bundle_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/if_fifo2.sv
// Two-entry registered FIFO of fetch bundles; head is always a register.
import if_pkg::*;

module if_fifo2 (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_bundle_t din,
    output fetch_bundle_t head,
    output logic [1:0]    count
);

    buf_state_t    state;
    fetch_bundle_t tail;

    assign count = state;

    // The caller never pops when empty nor pushes when full without popping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BUF_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            state <= BUF_EMPTY;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (state == BUF_EMPTY) begin
                        head  <= din;
                        state <= BUF_ONE;
                    end else begin
                        tail  <= din;
                        state <= BUF_FULL;
                    end
                end
                2'b01: begin
                    head  <= tail;
                    state <= (state == BUF_FULL) ? BUF_ONE : BUF_EMPTY;
                end
                2'b11: begin
                    if (state == BUF_FULL) begin
                        head <= tail;
                        tail <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, redirect/halt control and a 2-deep bundle buffer.
// Optional perf counters are enabled by defining IF_FETCH_PERF_EN.
import if_pkg::*;

module if_fetch_stage #(
    parameter int unsigned     PC_W     = IF_PC_W,
    parameter int unsigned     PC_STEP  = IF_PC_STEP,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(IF_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            halt,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] pc,
    input  logic [31:0]     ir,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_ir
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    logic          fetch;
    logic          pop;
    logic [1:0]    count;
    fetch_bundle_t din;
    fetch_bundle_t head;

    assign pop   = out_valid && out_ready;
    assign fetch = !halt && !redirect_valid && (count < 2'd2 || pop);

    assign din.pc = IF_PC_W'(pc);
    assign din.ir = ir;

    assign out_valid = (count != 2'd0);
    assign out_pc    = head.pc[PC_W-1:0];
    assign out_ir    = head.ir;

    // Redirect beats halt; the bundle on ir during a redirect is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[PC_W-1:1], 1'b0};
        end else if (fetch) begin
            pc <= pc + PC_W'(PC_STEP);
        end
    end

    if_fifo2 u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fetch),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (din),
        .head  (head),
        .count (count)
    );

`ifdef IF_FETCH_PERF_EN
    // A redirect discards everything currently held, including a head being popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (fetch) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (redirect_valid) begin
                perf_flushed <= perf_flushed + 32'(count);
            end
        end
    end
`endif

endmodule
